// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - single-byte I2C master sequencer; optional clock stretching via I2C_CLK_STRETCH_EN
module i2c_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  inout  wire        sda,
  inout  wire        scl
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RNACK, S_STOP
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [1:0]  qtr, qtr_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [7:0]  tx_sr, tx_nxt;
  logic [7:0]  rx_sr, rx_nxt;
  logic [7:0]  wd_q, wd_nxt;
  logic        rw_q, rw_nxt;
  logic        err, err_nxt;
  logic        sda_low, sda_low_nxt;
  logic        scl_low, scl_low_nxt;
  logic        done_nxt, ack_err_nxt;
  logic [7:0]  rdata_nxt;
  logic        tick, stretch_hold, sda_in;

  // Open-drain pads: the master only ever pulls low or lets go
  assign sda    = sda_low ? 1'b0 : 1'bz;
  assign scl    = scl_low ? 1'b0 : 1'bz;
  assign sda_in = sda;
  assign busy   = (state != S_IDLE);

  function automatic logic is_cell(input state_t s);
    return (s == S_ADDR) || (s == S_AACK) || (s == S_WDATA) ||
           (s == S_WACK) || (s == S_RDATA) || (s == S_RNACK);
  endfunction

`ifdef I2C_CLK_STRETCH_EN
  // Hold the divider at zero while a slave keeps scl low after we released it
  assign stretch_hold = (qtr == 2'd2) && (is_cell(state) || (state == S_STOP)) && (scl == 1'b0);
`else
  logic scl_unused;
  assign scl_unused   = scl;
  assign stretch_hold = 1'b0;
`endif

  assign tick = (state != S_IDLE) && !stretch_hold && (cnt == DIV_LAST);

  // State, divider, shift registers and registered line drivers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      qtr     <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      wd_q    <= '0;
      rw_q    <= 1'b0;
      err     <= 1'b0;
      sda_low <= 1'b0;
      scl_low <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      qtr     <= qtr_nxt;
      bit_cnt <= bit_nxt;
      tx_sr   <= tx_nxt;
      rx_sr   <= rx_nxt;
      wd_q    <= wd_nxt;
      rw_q    <= rw_nxt;
      err     <= err_nxt;
      sda_low <= sda_low_nxt;
      scl_low <= scl_low_nxt;
      done    <= done_nxt;
      ack_err <= ack_err_nxt;
      rdata   <= rdata_nxt;
    end
  end

  // Next-state sequencing; line levels are computed for the quarter being entered
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    qtr_nxt     = qtr;
    bit_nxt     = bit_cnt;
    tx_nxt      = tx_sr;
    rx_nxt      = rx_sr;
    wd_nxt      = wd_q;
    rw_nxt      = rw_q;
    err_nxt     = err;
    sda_low_nxt = sda_low;
    scl_low_nxt = scl_low;
    done_nxt    = 1'b0;
    ack_err_nxt = ack_err;
    rdata_nxt   = rdata;

    if (state == S_IDLE) begin
      cnt_nxt     = '0;
      qtr_nxt     = '0;
      bit_nxt     = '0;
      sda_low_nxt = 1'b0;
      scl_low_nxt = 1'b0;
      if (req) begin
        state_nxt = S_START;
        rw_nxt    = rw;
        tx_nxt    = {addr, rw};
        wd_nxt    = wdata;
        err_nxt   = 1'b0;
        rx_nxt    = '0;
      end
    end else begin
      if (stretch_hold || tick) cnt_nxt = '0;
      else                      cnt_nxt = cnt + 16'd1;

      if (tick) begin
        qtr_nxt = qtr + 2'd1;

        // End of a cell or phase: decide where to go
        if (qtr == 2'd3) begin
          case (state)
            S_START: begin
              state_nxt = S_ADDR;
              bit_nxt   = '0;
            end
            S_ADDR, S_WDATA: begin
              tx_nxt = {tx_sr[6:0], 1'b0};
              if (bit_cnt == 3'd7) begin
                bit_nxt   = '0;
                state_nxt = (state == S_ADDR) ? S_AACK : S_WACK;
              end else begin
                bit_nxt = bit_cnt + 3'd1;
              end
            end
            S_AACK: begin
              if (sda_in) begin
                err_nxt   = 1'b1;
                state_nxt = S_STOP;
              end else if (rw_q) begin
                state_nxt = S_RDATA;
              end else begin
                state_nxt = S_WDATA;
                tx_nxt    = wd_q;
              end
            end
            S_WACK: begin
              if (sda_in) err_nxt = 1'b1;
              state_nxt = S_STOP;
            end
            S_RDATA: begin
              rx_nxt = {rx_sr[6:0], sda_in};
              if (bit_cnt == 3'd7) begin
                bit_nxt   = '0;
                state_nxt = S_RNACK;
              end else begin
                bit_nxt = bit_cnt + 3'd1;
              end
            end
            S_RNACK: state_nxt = S_STOP;
            S_STOP: begin
              state_nxt   = S_IDLE;
              done_nxt    = 1'b1;
              ack_err_nxt = err;
              if (rw_q && !err) rdata_nxt = rx_sr;
            end
            default: state_nxt = S_IDLE;
          endcase
        end

        // Line actions at the start of the new quarter
        if (state_nxt == S_START) begin
          case (qtr_nxt)
            2'd2:    sda_low_nxt = 1'b1;
            2'd3:    scl_low_nxt = 1'b1;
            default: begin
              sda_low_nxt = 1'b0;
              scl_low_nxt = 1'b0;
            end
          endcase
        end else if (state_nxt == S_STOP) begin
          case (qtr_nxt)
            2'd0:    scl_low_nxt = 1'b1;
            2'd1:    sda_low_nxt = 1'b1;
            2'd2:    scl_low_nxt = 1'b0;
            default: sda_low_nxt = 1'b0;
          endcase
        end else if (state_nxt == S_IDLE) begin
          sda_low_nxt = 1'b0;
          scl_low_nxt = 1'b0;
        end else begin
          case (qtr_nxt)
            2'd0: scl_low_nxt = 1'b1;
            2'd1: begin
              if ((state_nxt == S_ADDR) || (state_nxt == S_WDATA)) sda_low_nxt = ~tx_nxt[7];
              else                                                 sda_low_nxt = 1'b0;
            end
            2'd2:    scl_low_nxt = 1'b0;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - directed table-driven bench for i2c_master_ctrl with a behavioural slave
module tb_i2c_master_ctrl;

  localparam int DIV = 4;
  localparam logic [6:0] SLV_ADDR = 7'h2A;
  localparam logic [7:0] RD_BYTE  = 8'hCC;
`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH_LAT = 80 * DIV + 50;
`else
  localparam int STRETCH_LAT = 80 * DIV;
`endif

  logic       clk = 1'b0;
  logic       rst_n, req, rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy, done, ack_err;
  logic [7:0] rdata;
  wire        sda_w, scl_w;

  pullup (sda_w);
  pullup (scl_w);

  i2c_master_ctrl #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
    .sda(sda_w), .scl(scl_w)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural slave at SLV_ADDR: ACKs, captures writes, returns RD_BYTE on reads
  logic       s_drv = 1'b0, s_hold = 1'b0, s_read = 1'b0, m_nack = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, stretch_arm = 1'b0;
  logic [7:0] s_sh = '0, wr_byte = '0;
  int         s_bits = 0, s_phase = 0, rises = 0, last_rises = 0;
  int         starts = 0, stops = 0, hold_left = 0, done_cnt = 0;

  assign sda_w = s_drv  ? 1'b0 : 1'bz;
  assign scl_w = s_hold ? 1'b0 : 1'bz;

  always @(posedge clk) if (done) done_cnt++;

  always @(negedge clk) begin
    if (scl_w && prev_scl && prev_sda && !sda_w) begin
      starts++; s_phase = 1; s_bits = 0; s_drv = 1'b0; rises = 0;
    end else if (scl_w && prev_scl && !prev_sda && sda_w) begin
      stops++; last_rises = rises; s_phase = 0; s_drv = 1'b0;
    end else if (scl_w && !prev_scl) begin
      rises++;
      if (s_bits < 8) s_sh = {s_sh[6:0], sda_w};
      else if (s_bits == 8 && s_phase == 3) m_nack = sda_w;
      s_bits++;
    end else if (!scl_w && prev_scl) begin
      if (stretch_arm && rises == 17) begin
        s_hold = 1'b1; hold_left = 58; stretch_arm = 1'b0;
      end
      if (s_phase != 0) begin
        if (s_bits == 8) begin
          if (s_phase == 1) begin
            if (s_sh[7:1] == SLV_ADDR) begin s_drv = 1'b1; s_read = s_sh[0]; end
            else begin s_phase = 0; s_drv = 1'b0; end
          end else if (s_phase == 2) begin
            wr_byte = s_sh; s_drv = 1'b1;
          end else begin
            s_drv = 1'b0;
          end
        end else if (s_bits == 9) begin
          s_bits = 0; s_drv = 1'b0;
          if (s_phase == 1) s_phase = s_read ? 3 : 2;
          else              s_phase = 0;
        end
        if (s_phase == 3 && s_bits < 8) s_drv = !RD_BYTE[7 - s_bits];
      end
    end
    if (s_hold) begin
      if (hold_left == 0) s_hold = 1'b0;
      else                hold_left--;
    end
    prev_scl = scl_w;
    prev_sda = sda_w;
  end

  // Present a request; returns at the negedge right after the accept edge
  task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d, input logic keep);
    @(negedge clk);
    req = 1'b1; rw = r; addr = a; wdata = d;
    @(negedge clk);
    if (!keep) req = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
  endtask

  // Counts clock edges from the accept edge until done is seen
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 3000);
  endtask

  typedef struct {
    logic       r;
    logic [6:0] a;
    logic [7:0] d;
    logic       e_err;
    logic [7:0] e_rdata;
    int         e_lat;
    int         e_rises;
    logic       chk_wr;
    logic       chk_nack;
  } vec_t;

  vec_t vecs[5];
  int   lat;
  int   s0, p0, d0;

  initial begin
    vecs[0] = '{1'b0, 7'h2A, 8'h5A, 1'b0, 8'h00, 80 * DIV, 19, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 7'h2A, 8'h00, 1'b0, 8'hCC, 80 * DIV, 19, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 7'h11, 8'h77, 1'b1, 8'hCC, 44 * DIV, 10, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 7'h11, 8'h00, 1'b1, 8'hCC, 44 * DIV, 10, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 7'h2A, 8'hA5, 1'b0, 8'hCC, 80 * DIV, 19, 1'b1, 1'b0};

    rst_n = 1'b0; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ack_err", ack_err, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_sda", sda_w, 1'b1);
    chk("rst_scl", scl_w, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      wr_byte = '0; m_nack = 1'b0;
      issue(vecs[i].r, vecs[i].a, vecs[i].d, 1'b0);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].e_lat);
      chk($sformatf("v%0d_ack_err", i), ack_err, vecs[i].e_err);
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_scl_rises", i), last_rises, vecs[i].e_rises);
      chk($sformatf("v%0d_bus_sda", i), sda_w, 1'b1);
      chk($sformatf("v%0d_bus_scl", i), scl_w, 1'b1);
      if (vecs[i].chk_wr)   chk($sformatf("v%0d_slave_byte", i), wr_byte, vecs[i].d);
      if (vecs[i].chk_nack) chk($sformatf("v%0d_master_nack", i), m_nack, 1'b1);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
      chk($sformatf("v%0d_rdata_hold", i), rdata, vecs[i].e_rdata);
    end

    // Back-to-back: req stays high through the first transaction
    s0 = starts; p0 = stops;
    issue(1'b0, 7'h2A, 8'h5A, 1'b1);
    wait_done(lat);
    chk("b2b_first_latency", lat, 80 * DIV);
    chk("b2b_first_starts", starts - s0, 1);
    @(negedge clk);
    chk("b2b_second_accept", busy, 1'b1);
    chk("b2b_done_fell", done, 1'b0);
    req = 1'b0;
    wait_done(lat);
    chk("b2b_second_latency", lat, 80 * DIV);
    chk("b2b_stops", stops - p0, 2);
    chk("b2b_starts", starts - s0, 2);

    // Reset pulse while in the third address cell (bit addr[4] = 0 is on sda)
    issue(1'b0, 7'h2A, 8'h5A, 1'b0);
    repeat (52) @(negedge clk);
    d0 = done_cnt;
    chk("mid_addr_scl_low", scl_w, 1'b0);
    chk("mid_addr_sda_low", sda_w, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_scl", scl_w, 1'b1);
    chk("async_rst_sda", sda_w, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_idle", busy, 1'b0);
    wr_byte = '0;
    issue(1'b0, 7'h2A, 8'h3C, 1'b0);
    wait_done(lat);
    chk("post_rst_latency", lat, 80 * DIV);
    chk("post_rst_ack_err", ack_err, 1'b0);
    chk("post_rst_slave_byte", wr_byte, 8'h3C);

    // Slave stretches scl during the write-ACK cell
    @(negedge clk);
    stretch_arm = 1'b1;
    issue(1'b0, 7'h2A, 8'h5A, 1'b0);
    wait_done(lat);
    chk("stretch_latency", lat, STRETCH_LAT);
    chk("stretch_ack_err", ack_err, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
